// File: rtl/conv_compute_if.sv
// conv_compute_if: AXI-stream result channel driven by conv_compute.
//   OUT_TDATA  : signed convolution result, OUTW bits
//   OUT_TVALID : result valid
//   OUT_TREADY : downstream ready
//   OUT_TLAST  : high with the final result of a run
interface conv_compute_if #(
  parameter int unsigned OUTW = 52
);
  logic [OUTW-1:0] OUT_TDATA;
  logic            OUT_TVALID;
  logic            OUT_TREADY;
  logic            OUT_TLAST;

  modport master (output OUT_TDATA, output OUT_TVALID, output OUT_TLAST, input OUT_TREADY);
  modport slave  (input  OUT_TDATA, input  OUT_TVALID, input  OUT_TLAST, output OUT_TREADY);
endinterface

// File: rtl/conv_compute.sv
// conv_compute: valid 2-D correlation engine, Y[i][j] = B + sum X[i+r][j+c]*W[r][c].
// Reads W (KxK) and X (RxC) through 1-cycle-latency synchronous read ports once
// inputs_loaded is high, streams (R-K+1)x(C-K+1) results in row-major order on
// out_if, then pulses compute_finished for one cycle.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   inputs_loaded     memories valid, K/B stable
//   K, B              filter size, signed bias
//   X_data, W_data    read data (1-cycle latency)
//   X_read_addr       row*C+col
//   W_read_addr       r*K+c
//   compute_finished  one-cycle done pulse
//   out_if            AXI-stream master (OUT_TDATA/TVALID/TREADY/TLAST)
// Optional build macro: CONV_RELU_EN clamps negative results to 0.
module conv_compute #(
  parameter int unsigned INW  = 24,
  parameter int unsigned R    = 9,
  parameter int unsigned C    = 8,
  parameter int unsigned MAXK = 4,
  parameter int unsigned OUTW = 52,
  localparam int unsigned K_BITS      = $clog2(MAXK + 1),
  localparam int unsigned X_ADDR_BITS = $clog2(R * C),
  localparam int unsigned W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputs_loaded,
  input  logic [K_BITS-1:0]      K,
  input  logic signed [INW-1:0]  B,
  input  logic signed [INW-1:0]  X_data,
  input  logic signed [INW-1:0]  W_data,
  output logic [X_ADDR_BITS-1:0] X_read_addr,
  output logic [W_ADDR_BITS-1:0] W_read_addr,
  output logic                   compute_finished,
  conv_compute_if.master         out_if
);
  localparam int unsigned I_BITS = $clog2(R + 1);
  localparam int unsigned J_BITS = $clog2(C + 1);
  localparam int unsigned N_BITS = $clog2(MAXK * MAXK + 1);
  localparam int unsigned PW     = 2 * INW;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_FINISH} state_e;

  state_e                  state_q, state_d;
  logic [K_BITS-1:0]       k_q, k_d;
  logic [I_BITS-1:0]       i_q, i_d;
  logic [J_BITS-1:0]       j_q, j_d;
  logic [N_BITS-1:0]       n_q, n_d;
  logic [K_BITS-1:0]       r_q, r_d;
  logic [K_BITS-1:0]       c_q, c_d;
  logic signed [OUTW-1:0]  acc_q, acc_d;
  logic [OUTW-1:0]         tdata_q, tdata_d;
  logic                    tlast_q, tlast_d;
  logic                    tvalid_q, tvalid_d;
  logic                    fin_q, fin_d;
  logic [X_ADDR_BITS-1:0]  xaddr_q, xaddr_d;
  logic [W_ADDR_BITS-1:0]  waddr_q, waddr_d;

  logic signed [PW-1:0]    prod_c;
  logic signed [OUTW-1:0]  sum_c;
  logic [OUTW-1:0]         res_c;
  logic [N_BITS-1:0]       kk_c;
  logic                    k_bad_c;
  logic                    last_pos_c;
  logic                    last_j_c;

  // X element address of tap (r,c) for output position (i,j)
  function automatic logic [X_ADDR_BITS-1:0] x_addr(input logic [I_BITS-1:0] i,
                                                     input logic [J_BITS-1:0] j,
                                                     input logic [K_BITS-1:0] r,
                                                     input logic [K_BITS-1:0] c);
    return X_ADDR_BITS'((int'(i) + int'(r)) * int'(C) + int'(j) + int'(c));
  endfunction

  // Datapath: product of the tap whose data is on the read ports this cycle
  assign prod_c = X_data * W_data;
  assign sum_c  = acc_q + OUTW'(prod_c);

`ifdef CONV_RELU_EN
  assign res_c = sum_c[OUTW-1] ? '0 : sum_c;
`else
  assign res_c = sum_c;
`endif

  assign kk_c       = N_BITS'(k_q) * N_BITS'(k_q);
  // K beyond MAXK would overrun the W address space, so it is treated like K>R/C
  assign k_bad_c    = (K == '0) || (int'(K) > int'(R)) || (int'(K) > int'(C)) ||
                      (int'(K) > int'(MAXK));
  assign last_j_c   = (int'(j_q) == int'(C) - int'(k_q));
  assign last_pos_c = (int'(i_q) == int'(R) - int'(k_q)) && last_j_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      c_q      <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      fin_q    <= 1'b0;
      xaddr_q  <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      i_q      <= i_d;
      j_q      <= j_d;
      n_q      <= n_d;
      r_q      <= r_d;
      c_q      <= c_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      fin_q    <= fin_d;
      xaddr_q  <= xaddr_d;
      waddr_q  <= waddr_d;
    end
  end

  // Next-state and registered-output logic; addresses default to 0
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    n_d      = n_q;
    r_d      = r_q;
    c_d      = c_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    fin_d    = 1'b0;
    xaddr_d  = '0;
    waddr_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (inputs_loaded) begin
          k_d = K;
          if (k_bad_c) begin
            state_d = S_FINISH;
            fin_d   = 1'b1;
          end else begin
            state_d = S_MAC;
            i_d     = '0;
            j_d     = '0;
            n_d     = '0;
            r_d     = '0;
            c_d     = '0;
            xaddr_d = x_addr('0, '0, '0, '0);
            waddr_d = '0;
          end
        end
      end

      S_MAC: begin
        // Cycle n presents tap n's address; its data is accumulated in cycle n+1
        acc_d = (n_q == '0) ? OUTW'(B) : sum_c;
        if (n_q == kk_c) begin
          state_d  = S_OUT;
          tvalid_d = 1'b1;
          tdata_d  = res_c;
          tlast_d  = last_pos_c;
        end else begin
          n_d = n_q + N_BITS'(1);
          if (c_q == k_q - K_BITS'(1)) begin
            c_d = '0;
            r_d = r_q + K_BITS'(1);
          end else begin
            c_d = c_q + K_BITS'(1);
          end
          if (n_d < kk_c) begin
            xaddr_d = x_addr(i_q, j_q, r_d, c_d);
            waddr_d = W_ADDR_BITS'(n_d);
          end
        end
      end

      S_OUT: begin
        if (out_if.OUT_TREADY) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          if (tlast_q) begin
            state_d = S_FINISH;
            fin_d   = 1'b1;
          end else begin
            state_d = S_MAC;
            n_d     = '0;
            r_d     = '0;
            c_d     = '0;
            if (last_j_c) begin
              j_d = '0;
              i_d = i_q + I_BITS'(1);
            end else begin
              j_d = j_q + J_BITS'(1);
            end
            xaddr_d = x_addr(i_d, j_d, '0, '0);
            waddr_d = '0;
          end
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
        i_d     = '0;
        j_d     = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign X_read_addr       = xaddr_q;
  assign W_read_addr       = waddr_q;
  assign compute_finished  = fin_q;
  assign out_if.OUT_TDATA  = tdata_q;
  assign out_if.OUT_TVALID = tvalid_q;
  assign out_if.OUT_TLAST  = tlast_q;

endmodule
